p2_mem_arb: RTL and testbench

P2_MEM_ARB -- requirements
Module: p2_mem_arb

---
 rtl/p2_mem_arb.sv | 105 ++++++++++
 tb/tb_p2_mem_arb.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/p2_mem_arb.sv
// p2_mem_arb: arbitrates CPU and video-refresh accesses onto one asynchronous P2 memory
// Ports:
//   clk40, reset_n   single clock, asynchronous active-low reset
//   cpu_*            CPU request/dtack port; one memory access per cpu_req (AS) cycle
//   vid_*            video read port; vid_ack pulses once per completed read
//   mem_*            registered memory address, write data and active-low strobes; mem_rdata in
module p2_mem_arb #(
    parameter int WAIT_STATES = 1
) (
    input  logic        clk40,
    input  logic        reset_n,
    input  logic        cpu_req,
    input  logic        cpu_rw,
    input  logic [19:0] cpu_addr,
    input  logic [1:0]  cpu_ds,
    input  logic [15:0] cpu_wdata,
    output logic [15:0] cpu_rdata,
    output logic        cpu_dtack,
    input  logic        vid_req,
    input  logic [19:0] vid_addr,
    output logic [15:0] vid_rdata,
    output logic        vid_ack,
    output logic [19:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    output logic        mem_ce_n,
    output logic        mem_oe_n,
    output logic        mem_we_n,
    output logic [1:0]  mem_be_n
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
    state_t state, state_nxt;
    logic [2:0] cnt;
    logic own_cpu, rd, last_cpu, armed;
    logic cpu_ok, gnt, gnt_cpu, acc_last;
    logic own_nxt, rd_nxt, acc_nxt, done_nxt;
    logic [1:0] be_nxt;

    // armed is cleared by a CPU grant and set again once cpu_req is seen low,
    // so a CPU holding its request after dtack gets no second access.
    assign cpu_ok   = cpu_req && armed;
    assign gnt      = (state == IDLE) && (cpu_ok || vid_req);
    // On a tie, whichever side did not win last time is granted.
    assign gnt_cpu  = cpu_ok && !(vid_req && last_cpu);
    assign acc_last = (state == ACCESS) && (cnt == 3'(WAIT_STATES));

    always_ff @(posedge clk40 or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = gnt ? ACCESS :
                    acc_last ? DONE :
                    (state == DONE && !(own_cpu && cpu_req)) ? IDLE : state;
    end

    // Strobes and acks are registered from the next-state values so they
    // change exactly on the state transitions without any input-to-pin path.
    always_comb begin
        own_nxt  = gnt ? gnt_cpu : own_cpu;
        rd_nxt   = gnt ? (!gnt_cpu || cpu_rw) : rd;
        acc_nxt  = state_nxt == ACCESS;
        done_nxt = state_nxt == DONE;
        be_nxt   = !acc_nxt ? 2'b11 : gnt ? (gnt_cpu ? ~cpu_ds : 2'b00) : mem_be_n;
    end

    always_ff @(posedge clk40 or negedge reset_n) begin
        if (!reset_n) begin
            cnt       <= 3'd0;
            own_cpu   <= 1'b0;
            rd        <= 1'b1;
            last_cpu  <= 1'b1;
            armed     <= 1'b1;
            mem_addr  <= 20'd0;
            mem_wdata <= 16'd0;
            mem_ce_n  <= 1'b1;
            mem_oe_n  <= 1'b1;
            mem_we_n  <= 1'b1;
            mem_be_n  <= 2'b11;
            cpu_dtack <= 1'b0;
            vid_ack   <= 1'b0;
            cpu_rdata <= 16'd0;
            vid_rdata <= 16'd0;
        end else begin
            cnt       <= (state == ACCESS) ? cnt + 3'd1 : 3'd0;
            own_cpu   <= own_nxt;
            rd        <= rd_nxt;
            armed     <= !cpu_req || (armed && !(gnt && gnt_cpu));
            mem_ce_n  <= !acc_nxt;
            mem_oe_n  <= !(acc_nxt && rd_nxt);
            mem_we_n  <= !(acc_nxt && !rd_nxt);
            mem_be_n  <= be_nxt;
            cpu_dtack <= done_nxt && own_nxt;
            vid_ack   <= done_nxt && !own_nxt;
            if (gnt) begin
                last_cpu  <= gnt_cpu;
                mem_addr  <= gnt_cpu ? cpu_addr : vid_addr;
                mem_wdata <= cpu_wdata;
            end
            if (acc_last && own_cpu)  cpu_rdata <= mem_rdata;
            if (acc_last && !own_cpu) vid_rdata <= mem_rdata;
        end
    end
endmodule

// File: tb/tb_p2_mem_arb.sv
// tb_p2_mem_arb: directed vectors plus randomized traffic for p2_mem_arb against a timestamp-based model
// Ports: none (drives clk40/reset_n and all DUT inputs, checks every DUT output each cycle)
module tb_p2_mem_arb;
    localparam int WS = 1;

    logic        clk40 = 1'b0;
    logic        reset_n = 1'b1;
    logic        cpu_req = 1'b0;
    logic        cpu_rw = 1'b1;
    logic [19:0] cpu_addr = 20'd0;
    logic [1:0]  cpu_ds = 2'b00;
    logic [15:0] cpu_wdata = 16'd0;
    logic [15:0] cpu_rdata;
    logic        cpu_dtack;
    logic        vid_req = 1'b0;
    logic [19:0] vid_addr = 20'd0;
    logic [15:0] vid_rdata;
    logic        vid_ack;
    logic [19:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata = 16'd0;
    logic        mem_ce_n, mem_oe_n, mem_we_n;
    logic [1:0]  mem_be_n;

    p2_mem_arb #(.WAIT_STATES(WS)) dut (
        .clk40(clk40), .reset_n(reset_n),
        .cpu_req(cpu_req), .cpu_rw(cpu_rw), .cpu_addr(cpu_addr), .cpu_ds(cpu_ds),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_dtack(cpu_dtack),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_rdata(vid_rdata), .vid_ack(vid_ack),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ce_n(mem_ce_n), .mem_oe_n(mem_oe_n), .mem_we_n(mem_we_n), .mem_be_n(mem_be_n)
    );

    always #5 clk40 = ~clk40;

    int n_chk = 0, n_err = 0, cyc = 0;
    bit chk_on = 0, cpu_done = 0;
    logic [15:0] img [int];

    // Model: one transaction at a time, described by its grant cycle t0.
    // Strobes are low in cycles t0+1..t0+WS+1, the ack starts at t0+WS+2.
    bit          m_busy, m_cpu, m_rw, m_last_cpu, m_armed;
    int          m_t0;
    logic [19:0] m_addr;
    logic [1:0]  m_ds;
    logic [15:0] m_wdata;

    typedef struct {
        logic        rw;
        logic [19:0] addr;
        logic [1:0]  ds;
        logic [15:0] wdata;
        logic [15:0] mdat;
        logic [1:0]  be_n;
        logic        oe_n;
        logic        we_n;
    } vec_t;
    vec_t tbl [4];

    task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, got, exp);
        end
    endtask

    function automatic logic [15:0] mem_val(logic [19:0] a);
        return img.exists(int'(a)) ? img[int'(a)] : (a[15:0] ^ {4'h0, a[19:8]} ^ 16'h5a5a);
    endfunction

    function void m_reset();
        m_busy = 0;
        m_last_cpu = 1;
        m_armed = 1;
        m_addr = 20'd0;
    endfunction

    task automatic tick();
        @(posedge clk40);
        #1;
    endtask

    always @(posedge clk40) begin
        if (!reset_n) m_reset();
        else begin
            if (!cpu_req) m_armed = 1;
            if (m_busy) begin
                if (cyc >= m_t0 + WS + 2 && !(m_cpu && cpu_req)) m_busy = 0;
            end else if (vid_req || (cpu_req && m_armed)) begin
                m_cpu = cpu_req && m_armed && !(vid_req && m_last_cpu);
                m_busy = 1;
                m_t0 = cyc;
                m_last_cpu = m_cpu;
                m_rw = m_cpu ? cpu_rw : 1'b1;
                m_addr = m_cpu ? cpu_addr : vid_addr;
                m_ds = cpu_ds;
                m_wdata = cpu_wdata;
                if (m_cpu) m_armed = 0;
            end
        end
        cyc++;
        // valid data only in the last strobe cycle, so early/late capture shows up
        mem_rdata <= (m_busy && cyc == m_t0 + WS + 1) ? mem_val(m_addr) : 16'hdead ^ 16'(cyc);
    end

    always @(negedge clk40) if (chk_on) begin
        logic acc, dn, rd;
        logic [1:0] ebe;
        if (!reset_n) m_reset();
        acc = m_busy && cyc <= m_t0 + WS + 1;
        dn  = m_busy && cyc >= m_t0 + WS + 2;
        rd  = !m_cpu || m_rw;
        ebe = !acc ? 2'b11 : m_cpu ? ~m_ds : 2'b00;
        chk("ce_n", mem_ce_n, !acc);
        chk("oe_n", mem_oe_n, !(acc && rd));
        chk("we_n", mem_we_n, !(acc && !rd));
        chk("be_n", mem_be_n, ebe);
        chk("dtack", cpu_dtack, dn && m_cpu);
        chk("vid_ack", vid_ack, dn && !m_cpu);
        if (m_busy) chk("mem_addr", mem_addr, m_addr);
        if (acc && !rd) chk("mem_wdata", mem_wdata, m_wdata);
        if (dn && m_cpu && m_rw) chk("cpu_rdata", cpu_rdata, mem_val(m_addr));
        if (dn && !m_cpu) chk("vid_rdata", vid_rdata, mem_val(m_addr));
        if (!reset_n) begin
            chk("rst_cpu_rdata", cpu_rdata, 0);
            chk("rst_vid_rdata", vid_rdata, 0);
            chk("rst_mem_addr", mem_addr, 0);
            chk("rst_mem_wdata", mem_wdata, 0);
        end
    end

    task automatic wait_dtack(int lim, string name);
        bit got = 0;
        for (int i = 0; i < lim && !got; i++) begin
            @(negedge clk40);
            got = cpu_dtack;
        end
        chk(name, got, 1);
    endtask

    task automatic cpu_rand();
        repeat ($urandom_range(0, 4)) tick();
        cpu_req = 1;
        cpu_rw = 1'($urandom);
        cpu_addr = 20'($urandom);
        cpu_ds = 2'($urandom);
        cpu_wdata = 16'($urandom);
        if ($urandom_range(0, 7) == 0) repeat ($urandom_range(1, 3)) tick();
        else begin
            wait_dtack(40, "rnd_dtack_wait");
            repeat ($urandom_range(1, 3)) tick();
        end
        cpu_req = 0;
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int seq[$];
        bit dt_seen, prev_dt;
        tbl[0] = '{1'b0, 20'h00000, 2'b11, 16'h00a5, 16'h0000, 2'b00, 1'b1, 1'b0};
        tbl[1] = '{1'b1, 20'h01234, 2'b01, 16'h0000, 16'hbeef, 2'b10, 1'b0, 1'b1};
        tbl[2] = '{1'b1, 20'hfffff, 2'b10, 16'h0000, 16'h1357, 2'b01, 1'b0, 1'b1};
        tbl[3] = '{1'b0, 20'h80001, 2'b01, 16'hffff, 16'h0000, 2'b10, 1'b1, 1'b0};

        #1 reset_n = 0;
        chk_on = 1;
        @(negedge clk40);
        chk("rst_ce_n", mem_ce_n, 1);
        chk("rst_oe_n", mem_oe_n, 1);
        chk("rst_we_n", mem_we_n, 1);
        chk("rst_be_n", mem_be_n, 2'b11);
        chk("rst_dtack", cpu_dtack, 0);
        chk("rst_vid_ack", vid_ack, 0);
        tick();
        reset_n = 1;
        tick();
        tick();

        // single CPU accesses, no video traffic
        for (int i = 0; i < 4; i++) begin
            if (tbl[i].rw) img[int'(tbl[i].addr)] = tbl[i].mdat;
            tick();
            cpu_req = 1;
            cpu_rw = tbl[i].rw;
            cpu_addr = tbl[i].addr;
            cpu_ds = tbl[i].ds;
            cpu_wdata = tbl[i].wdata;
            for (int k = 0; k < 6; k++) begin
                @(negedge clk40);
                chk("t_ce_n", mem_ce_n, !(k == 1 || k == 2));
                chk("t_dtack", cpu_dtack, k >= 3);
                if (k == 1 || k == 2) begin
                    chk("t_oe_n", mem_oe_n, tbl[i].oe_n);
                    chk("t_we_n", mem_we_n, tbl[i].we_n);
                    chk("t_be_n", mem_be_n, tbl[i].be_n);
                    chk("t_addr", mem_addr, tbl[i].addr);
                    if (!tbl[i].rw) chk("t_wdata", mem_wdata, tbl[i].wdata);
                end
                if (k >= 3 && tbl[i].rw) chk("t_rdata", cpu_rdata, tbl[i].mdat);
            end
            tick();
            cpu_req = 0;
            @(negedge clk40);
            chk("t_dtack_last", cpu_dtack, 1);
            @(negedge clk40);
            chk("t_dtack_off", cpu_dtack, 0);
        end

        // both requests rise together out of reset: video first, then CPU
        tick();
        reset_n = 0;
        tick();
        tick();
        reset_n = 1;
        cpu_req = 1;
        cpu_rw = 1;
        cpu_addr = 20'h00100;
        vid_req = 1;
        vid_addr = 20'h00200;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk40);
            chk("p_vid_ack", vid_ack, k == 3);
            chk("p_dtack", cpu_dtack, k == 7);
        end
        // both kept busy: completions must alternate starting with video
        dt_seen = 1;
        prev_dt = 1;
        for (int n = 0; n < 80; n++) begin
            tick();
            if (!cpu_req) cpu_req = 1;
            else if (dt_seen) cpu_req = 0;
            @(negedge clk40);
            dt_seen = cpu_dtack;
            if (vid_ack) seq.push_back(0);
            if (cpu_dtack && !prev_dt) seq.push_back(1);
            prev_dt = cpu_dtack;
        end
        chk("alt_count", seq.size() >= 6, 1);
        foreach (seq[i]) chk("alt_order", seq[i], i % 2);
        tick();
        cpu_req = 0;
        vid_req = 0;
        tick();
        tick();

        // CPU holding its request after dtack gets no second access
        cpu_req = 1;
        cpu_rw = 0;
        cpu_addr = 20'h00777;
        cpu_wdata = 16'h1234;
        cpu_ds = 2'b11;
        wait_dtack(10, "h_dtack1");
        repeat (15) begin
            @(negedge clk40);
            chk("h_hold_dtack", cpu_dtack, 1);
            chk("h_no_access", mem_ce_n, 1);
        end
        tick();
        cpu_req = 0;
        tick();
        @(negedge clk40);
        chk("h_dtack_off", cpu_dtack, 0);
        tick();
        cpu_req = 1;
        wait_dtack(10, "h_dtack2");
        tick();
        cpu_req = 0;
        tick();
        tick();

        // reset in the middle of a video access, then re-served once
        vid_req = 1;
        vid_addr = 20'h0abcd;
        tick();
        @(negedge clk40);
        chk("r_pre_ce", mem_ce_n, 0);
        tick();
        reset_n = 0;
        @(negedge clk40);
        chk("r_ce_n", mem_ce_n, 1);
        chk("r_oe_n", mem_oe_n, 1);
        chk("r_be_n", mem_be_n, 2'b11);
        chk("r_ack", vid_ack, 0);
        tick();
        @(negedge clk40);
        chk("r_ack_held", vid_ack, 0);
        tick();
        reset_n = 1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk40);
            chk("r_vid_ack", vid_ack, k == 3);
        end
        tick();
        vid_req = 0;
        tick();
        tick();

        // randomized mixed traffic against the model
        fork
            begin
                repeat (150) cpu_rand();
                cpu_done = 1;
            end
            begin
                while (!cpu_done) begin
                    tick();
                    if ($urandom_range(0, 5) == 0) vid_req = !vid_req;
                    vid_addr = 20'($urandom);
                end
            end
        join
        vid_req = 0;
        cpu_req = 0;
        repeat (8) tick();
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
